// File: rtl/uart_arb_pkg.sv
// Shared encodings and default constants for the two-requester UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_REQ0 = 1'b0,
        OWN_REQ1 = 1'b1
    } arb_owner_t;

    localparam int DATA_W_DEF      = 8;
    localparam int MAX_BURST_DEF   = 64;
    localparam int CNT_W_DEF       = 7;
    localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to rr_ptr.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_rr_ptr,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    logic w_tie;

    assign w_tie         = &i_valid;
    assign o_grant_valid = |i_valid;
    assign o_grant_idx   = w_tie ? i_rr_ptr : i_valid[OWN_REQ1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART TX serializer between two byte streams.
// Define UART_ARB_TIMEOUT_EN to add the owner-stall timeout and the STALL_ABORT port.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_BURST   = MAX_BURST_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    input  logic [DATA_W-1:0] REQ0_DATA,
    input  logic              REQ0_LAST,
    output logic              REQ0_READY,
    input  logic              REQ1_VALID,
    input  logic [DATA_W-1:0] REQ1_DATA,
    input  logic              REQ1_LAST,
    output logic              REQ1_READY,
    output logic              TX_VALID,
    output logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_READY,
    output logic [1:0]        GNT,
    output logic              ARB_BUSY
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic              STALL_ABORT
`endif
);

    arb_state_t       r_state;
    arb_owner_t       r_owner;
    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [1:0]       r_gnt;
    logic             r_arb_busy;

    logic              w_busy;
    logic              w_own_valid;
    logic              w_own_last;
    logic [DATA_W-1:0] w_own_data;
    logic              w_hs;
    logic              w_burst_end;
    logic              w_release;
    logic              w_timeout;
    logic              w_drop;
    logic              w_pick_valid;
    logic              w_pick_idx;

    uart_arb_rr_pick u_pick (
        .i_valid       ({REQ1_VALID, REQ0_VALID}),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant_valid (w_pick_valid),
        .o_grant_idx   (w_pick_idx)
    );

    assign w_busy      = (r_state == ST_BUSY);
    assign w_own_valid = (r_owner == OWN_REQ1) ? REQ1_VALID : REQ0_VALID;
    assign w_own_last  = (r_owner == OWN_REQ1) ? REQ1_LAST  : REQ0_LAST;
    assign w_own_data  = (r_owner == OWN_REQ1) ? REQ1_DATA  : REQ0_DATA;

    // Zero-latency pass-through from the owner; the non-owner is held off via READY.
    assign TX_VALID   = w_busy & w_own_valid;
    assign TX_DATA    = TX_VALID ? w_own_data : '0;
    assign REQ0_READY = w_busy & (r_owner == OWN_REQ0) & TX_READY;
    assign REQ1_READY = w_busy & (r_owner == OWN_REQ1) & TX_READY;

    assign w_hs        = TX_VALID & TX_READY;
    assign w_burst_end = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_release   = w_hs & (w_own_last | w_burst_end);
    assign w_drop      = w_release | w_timeout;

    assign GNT      = r_gnt;
    assign ARB_BUSY = r_arb_busy;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_stall_abort;

    assign w_timeout   = w_busy & ~w_own_valid & (r_stall_cnt == STALL_W'(TIMEOUT_CYC - 1));
    assign STALL_ABORT = r_stall_abort;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_cnt   <= '0;
            r_stall_abort <= 1'b0;
        end else begin
            r_stall_abort <= w_timeout;
            if (!w_busy || w_own_valid) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_REQ0;
            r_rr_ptr    <= 1'b0;
            r_burst_cnt <= '0;
            r_gnt       <= 2'b00;
            r_arb_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state     <= ST_BUSY;
                        r_owner     <= arb_owner_t'(w_pick_idx);
                        r_gnt       <= w_pick_idx ? 2'b10 : 2'b01;
                        r_arb_busy  <= 1'b1;
                        r_burst_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    // Every release returns to IDLE, giving the other side one cycle to win.
                    if (w_drop) begin
                        r_state     <= ST_IDLE;
                        r_rr_ptr    <= (r_owner == OWN_REQ0);
                        r_burst_cnt <= '0;
                        r_gnt       <= 2'b00;
                        r_arb_busy  <= 1'b0;
                    end else if (w_hs) begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (MAX_BURST=4, TIMEOUT_CYC=8); stall cases need UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       REQ0_VALID = 1'b0;
    logic [7:0] REQ0_DATA = 8'h00;
    logic       REQ0_LAST = 1'b0;
    logic       REQ0_READY;
    logic       REQ1_VALID = 1'b0;
    logic [7:0] REQ1_DATA = 8'h00;
    logic       REQ1_LAST = 1'b0;
    logic       REQ1_READY;
    logic       TX_VALID;
    logic [7:0] TX_DATA;
    logic       TX_READY = 1'b0;
    logic [1:0] GNT;
    logic       ARB_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
    logic       STALL_ABORT;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    uart_tx_arbiter #(
        .DATA_W      (8),
        .MAX_BURST   (4),
        .CNT_W       (7),
        .TIMEOUT_CYC (8)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ0_VALID  (REQ0_VALID),
        .REQ0_DATA   (REQ0_DATA),
        .REQ0_LAST   (REQ0_LAST),
        .REQ0_READY  (REQ0_READY),
        .REQ1_VALID  (REQ1_VALID),
        .REQ1_DATA   (REQ1_DATA),
        .REQ1_LAST   (REQ1_LAST),
        .REQ1_READY  (REQ1_READY),
        .TX_VALID    (TX_VALID),
        .TX_DATA     (TX_DATA),
        .TX_READY    (TX_READY),
        .GNT         (GNT),
        .ARB_BUSY    (ARB_BUSY)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .STALL_ABORT (STALL_ABORT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge; inputs are driven here, outputs checked 1 ns later.
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs();
        REQ0_VALID = 1'b0; REQ0_DATA = 8'h00; REQ0_LAST = 1'b0;
        REQ1_VALID = 1'b0; REQ1_DATA = 8'h00; REQ1_LAST = 1'b0;
        TX_READY   = 1'b1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        RESET = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle_inputs();
        cyc();
        #1;
        check_val("rst_gnt",    GNT, 2'b00);
        check_val("rst_busy",   ARB_BUSY, 1'b0);
        check_val("rst_txv",    TX_VALID, 1'b0);
        check_val("rst_txd",    TX_DATA, 8'h00);
        check_val("rst_rdy0",   REQ0_READY, 1'b0);
        check_val("rst_rdy1",   REQ1_READY, 1'b0);
        check_val("rst_rr",     dut.r_rr_ptr, 1'b0);
        check_val("rst_cnt",    dut.r_burst_cnt, 7'd0);
`ifdef UART_ARB_TIMEOUT_EN
        check_val("rst_stall",  STALL_ABORT, 1'b0);
`endif
        cyc();
        RESET = 1'b1;

        // REQ0 alone: 0x41 0x42 0x43(LAST)
        REQ0_VALID = 1'b1; REQ0_DATA = 8'h41; REQ0_LAST = 1'b0;
        #1;
        check_val("t1_idle_gnt", GNT, 2'b00);
        check_val("t1_idle_txv", TX_VALID, 1'b0);
        cyc(); #1;
        check_val("t1_gnt",   GNT, 2'b01);
        check_val("t1_busy",  ARB_BUSY, 1'b1);
        check_val("t1_b0",    TX_DATA, 8'h41);
        check_val("t1_rdy0",  REQ0_READY, 1'b1);
        cyc(); REQ0_DATA = 8'h42; #1;
        check_val("t1_b1",    TX_DATA, 8'h42);
        cyc(); REQ0_DATA = 8'h43; REQ0_LAST = 1'b1; #1;
        check_val("t1_b2",    TX_DATA, 8'h43);
        check_val("t1_txv",   TX_VALID, 1'b1);
        cyc(); REQ0_VALID = 1'b0; REQ0_LAST = 1'b0; #1;
        check_val("t1_end_gnt",  GNT, 2'b00);
        check_val("t1_end_busy", ARB_BUSY, 1'b0);
        check_val("t1_end_rr",   dut.r_rr_ptr, 1'b1);
        check_val("t1_end_cnt",  dut.r_burst_cnt, 7'd0);

        // Tie after reset: REQ0 first, then REQ1 after the bubble
        do_reset();
        REQ0_VALID = 1'b1; REQ0_DATA = 8'h10; REQ0_LAST = 1'b0;
        REQ1_VALID = 1'b1; REQ1_DATA = 8'h20; REQ1_LAST = 1'b1;
        #1;
        check_val("t2_idle_gnt", GNT, 2'b00);
        cyc(); #1;
        check_val("t2_gnt0",  GNT, 2'b01);
        check_val("t2_b0",    TX_DATA, 8'h10);
        check_val("t2_rdy1a", REQ1_READY, 1'b0);
        cyc(); REQ0_DATA = 8'h11; REQ0_LAST = 1'b1; #1;
        check_val("t2_b1",    TX_DATA, 8'h11);
        check_val("t2_rdy1b", REQ1_READY, 1'b0);
        cyc(); REQ0_VALID = 1'b0; REQ0_LAST = 1'b0; #1;
        check_val("t2_bubble", GNT, 2'b00);
        check_val("t2_rdy1c",  REQ1_READY, 1'b0);
        cyc(); #1;
        check_val("t2_gnt1",  GNT, 2'b10);
        check_val("t2_r1b0",  TX_DATA, 8'h20);
        check_val("t2_rdy1d", REQ1_READY, 1'b1);
        check_val("t2_rdy0",  REQ0_READY, 1'b0);
        cyc(); REQ1_VALID = 1'b0; REQ1_LAST = 1'b0; #1;
        check_val("t2_end_gnt", GNT, 2'b00);
        check_val("t2_end_rr",  dut.r_rr_ptr, 1'b0);

        // MAX_BURST=4: REQ1 streams without LAST while REQ0 is pending
        REQ1_VALID = 1'b1; REQ1_DATA = 8'h80; REQ1_LAST = 1'b0;
        cyc(); REQ0_VALID = 1'b1; REQ0_DATA = 8'h55; REQ0_LAST = 1'b0; #1;
        check_val("t3_gnt1",  GNT, 2'b10);
        check_val("t3_b0",    TX_DATA, 8'h80);
        check_val("t3_rdy0a", REQ0_READY, 1'b0);
        for (int i = 1; i < 4; i++) begin
            cyc(); REQ1_DATA = 8'h80 + 8'(i); #1;
            check_val("t3_bn",   TX_DATA, 32'h80 + i);
            check_val("t3_cnt",  dut.r_burst_cnt, i);
            check_val("t3_rdy0", REQ0_READY, 1'b0);
        end
        cyc(); REQ1_DATA = 8'h84; #1;
        check_val("t3_cap_gnt", GNT, 2'b00);
        check_val("t3_cap_txv", TX_VALID, 1'b0);
        check_val("t3_cap_rr",  dut.r_rr_ptr, 1'b0);
        cyc(); #1;
        check_val("t3_gnt0",  GNT, 2'b01);
        check_val("t3_r0b0",  TX_DATA, 8'h55);
        check_val("t3_rdy1",  REQ1_READY, 1'b0);
        cyc(); REQ0_DATA = 8'h56; REQ0_LAST = 1'b1; #1;
        check_val("t3_r0b1",  TX_DATA, 8'h56);
        cyc(); REQ0_VALID = 1'b0; REQ0_LAST = 1'b0; #1;
        check_val("t3_bubble", GNT, 2'b00);
        check_val("t3_rr1",    dut.r_rr_ptr, 1'b1);
        cyc(); REQ1_LAST = 1'b1; #1;
        check_val("t3_resume_gnt", GNT, 2'b10);
        check_val("t3_resume_b",   TX_DATA, 8'h84);
        cyc(); REQ1_VALID = 1'b0; REQ1_LAST = 1'b0; #1;
        check_val("t3_end_gnt", GNT, 2'b00);

        // TX_READY 1,0,0,1 during a REQ0 message
        REQ0_VALID = 1'b1; REQ0_DATA = 8'hA0; REQ0_LAST = 1'b0; TX_READY = 1'b1;
        cyc(); #1;
        check_val("t4_gnt",  GNT, 2'b01);
        check_val("t4_b0",   TX_DATA, 8'hA0);
        cyc(); REQ0_DATA = 8'hA1; TX_READY = 1'b0; #1;
        check_val("t4_hold_a",  TX_DATA, 8'hA1);
        check_val("t4_rdy0_lo", REQ0_READY, 1'b0);
        cyc(); #1;
        check_val("t4_hold_b",  TX_DATA, 8'hA1);
        check_val("t4_cnt1",    dut.r_burst_cnt, 7'd1);
        cyc(); TX_READY = 1'b1; #1;
        check_val("t4_hold_c",  TX_DATA, 8'hA1);
        check_val("t4_rdy0_hi", REQ0_READY, 1'b1);
        cyc(); TX_READY = 1'b0; REQ0_VALID = 1'b0; #1;
        check_val("t4_cnt2",    dut.r_burst_cnt, 7'd2);
        check_val("t4_keep",    GNT, 2'b01);
        check_val("t4_drop_txv", TX_VALID, 1'b0);
        check_val("t4_drop_txd", TX_DATA, 8'h00);
        cyc(); REQ0_VALID = 1'b1; REQ0_DATA = 8'hA2; REQ0_LAST = 1'b1; TX_READY = 1'b1; #1;
        check_val("t4_b2",   TX_DATA, 8'hA2);
        cyc(); REQ0_VALID = 1'b0; REQ0_LAST = 1'b0; #1;
        check_val("t4_end_gnt", GNT, 2'b00);
        check_val("t4_end_rr",  dut.r_rr_ptr, 1'b1);

        // Asynchronous reset during byte 2 of a REQ1 message
        REQ1_VALID = 1'b1; REQ1_DATA = 8'hC0; REQ1_LAST = 1'b0;
        cyc(); #1;
        check_val("t5_gnt1", GNT, 2'b10);
        check_val("t5_b0",   TX_DATA, 8'hC0);
        cyc(); REQ1_DATA = 8'hC1; #1;
        check_val("t5_b1",   TX_DATA, 8'hC1);
        RESET = 1'b0;
        #1;
        check_val("t5_rst_txv",  TX_VALID, 1'b0);
        check_val("t5_rst_txd",  TX_DATA, 8'h00);
        check_val("t5_rst_rdy1", REQ1_READY, 1'b0);
        check_val("t5_rst_gnt",  GNT, 2'b00);
        check_val("t5_rst_busy", ARB_BUSY, 1'b0);
        cyc();
        RESET = 1'b1;
        REQ0_VALID = 1'b1; REQ0_DATA = 8'hD0; REQ0_LAST = 1'b1;
        #1;
        check_val("t5_rr0",    dut.r_rr_ptr, 1'b0);
        check_val("t5_idle",   GNT, 2'b00);
        cyc(); #1;
        check_val("t5_tie_gnt", GNT, 2'b01);
        check_val("t5_tie_b",   TX_DATA, 8'hD0);
        check_val("t5_rdy1",    REQ1_READY, 1'b0);
        cyc(); REQ0_VALID = 1'b0; REQ0_LAST = 1'b0; REQ1_VALID = 1'b0; #1;
        check_val("t5_end_gnt", GNT, 2'b00);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner stalls after byte 1 while REQ1 waits
        REQ0_VALID = 1'b1; REQ0_DATA = 8'hE0; REQ0_LAST = 1'b0;
        cyc(); #1;
        check_val("t6_gnt0", GNT, 2'b01);
        cyc(); REQ0_VALID = 1'b0; REQ1_VALID = 1'b1; REQ1_DATA = 8'hF0; REQ1_LAST = 1'b1; #1;
        for (int i = 1; i <= 8; i++) begin
            check_val("t6_stall_lo",  STALL_ABORT, 1'b0);
            check_val("t6_stall_gnt", GNT, 2'b01);
            cyc(); #1;
        end
        check_val("t6_abort",     STALL_ABORT, 1'b1);
        check_val("t6_abort_gnt", GNT, 2'b00);
        check_val("t6_abort_rr",  dut.r_rr_ptr, 1'b1);
        cyc(); #1;
        check_val("t6_pulse_end", STALL_ABORT, 1'b0);
        check_val("t6_gnt1",      GNT, 2'b10);
        check_val("t6_r1b",       TX_DATA, 8'hF0);
        cyc(); REQ1_VALID = 1'b0; REQ1_LAST = 1'b0; #1;
        check_val("t6_end_gnt",   GNT, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
